// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a single-cycle hart.
//   Byte-addressed little-endian RAM with combinational read and masked
//   synchronous write, plus a 16-byte MMIO window:
//     0x0 TOHOST (rw), 0x4 CYCLE (ro), 0x8 LOADS (ro), 0xC STORES (ro).
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_dmem_addr/ren/wen    request address and load/store strobes
//   i_dmem_wdata/mask      lane-aligned store data and byte enables
//   o_dmem_rdata           combinational load data (0 when idle or on a miss)
//   o_fault                combinational: active request hits no region
//   o_tohost_valid/data    registered tohost status and value
//   o_load_count/store_count  accepted-access counters
// Optional build macro: DMEM_STATS_EN enables the load/store counters;
// without it the counters read as zero and no counter flops exist.
module dmem_responder #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_fault,
  output logic        o_tohost_valid,
  output logic [31:0] o_tohost_data,
  output logic [31:0] o_load_count,
  output logic [31:0] o_store_count
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];

  logic [31:0]   ram_off;
  logic          ram_hit;
  logic          mmio_sel;
  logic          miss;
  logic          accept;
  logic [AW-1:0] bidx [4];
  logic [31:0]   ram_word;
  logic [31:0]   mmio_word;
  logic          ram_we;

  logic          tohost_valid_q, tohost_valid_d;
  logic [31:0]   tohost_data_q,  tohost_data_d;
  logic [31:0]   cycle_q,        cycle_d;
  logic [31:0]   load_count_v;
  logic [31:0]   store_count_v;

  // Region decode; RAM wins if the two regions were ever configured to overlap.
  always_comb begin
    ram_off  = i_dmem_addr - MEM_BASE;
    ram_hit  = (ram_off < MEM_BYTES);
    mmio_sel = !ram_hit && (i_dmem_addr[31:4] == MMIO_BASE[31:4]) &&
               (i_dmem_addr[1:0] == 2'b00);
    miss     = !ram_hit && !mmio_sel;
    accept   = !miss;
    o_fault  = (i_dmem_ren | i_dmem_wen) & miss;
  end

  // Byte indices wrap modulo MEM_BYTES through the AW-bit addition.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      bidx[n] = ram_off[AW-1:0] + AW'(n);
    end
    ram_word = {mem[bidx[3]], mem[bidx[2]], mem[bidx[1]], mem[bidx[0]]};
  end

  // MMIO read mux.
  always_comb begin
    mmio_word = '0;
    case (i_dmem_addr[3:2])
      2'd0:    mmio_word = tohost_data_q;
      2'd1:    mmio_word = cycle_q;
      2'd2:    mmio_word = load_count_v;
      default: mmio_word = store_count_v;
    endcase
  end

  // Load data: pre-write value on a same-cycle read/write.
  always_comb begin
    o_dmem_rdata = '0;
    if (i_dmem_ren && ram_hit) begin
      o_dmem_rdata = ram_word;
    end else if (i_dmem_ren && mmio_sel) begin
      o_dmem_rdata = mmio_word;
    end
  end

  // RAM write port; contents are never reset, stores during reset are dropped.
  assign ram_we = i_rst_n && i_dmem_wen && ram_hit;

  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      for (int n = 0; n < 4; n++) begin
        if (i_dmem_mask[n]) begin
          mem[bidx[n]] <= i_dmem_wdata[8*n +: 8];
        end
      end
    end
  end

  // Next state for tohost and the free-running cycle counter.
  always_comb begin
    tohost_valid_d = tohost_valid_q;
    tohost_data_d  = tohost_data_q;
    cycle_d        = cycle_q + 32'd1;
    if (i_dmem_wen && mmio_sel && (i_dmem_addr[3:2] == 2'd0) && (|i_dmem_mask)) begin
      tohost_valid_d = 1'b1;
      for (int n = 0; n < 4; n++) begin
        if (i_dmem_mask[n]) begin
          tohost_data_d[8*n +: 8] = i_dmem_wdata[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
      cycle_q        <= '0;
    end else begin
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
      cycle_q        <= cycle_d;
    end
  end

  assign o_tohost_valid = tohost_valid_q;
  assign o_tohost_data  = tohost_data_q;

`ifdef DMEM_STATS_EN
  logic [31:0] load_count_q,  load_count_d;
  logic [31:0] store_count_q, store_count_d;

  // Accepted accesses only; a cycle with ren and wen bumps both counters.
  always_comb begin
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    if (i_dmem_ren && accept) begin
      load_count_d = load_count_q + 32'd1;
    end
    if (i_dmem_wen && accept) begin
      store_count_d = store_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign load_count_v  = load_count_q;
  assign store_count_v = store_count_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign load_count_v  = '0;
  assign store_count_v = '0;
`endif

  assign o_load_count  = load_count_v;
  assign o_store_count = store_count_v;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: each issued request pushes its
// expected rdata/fault, popped and compared mid-cycle.
module tb_dmem_responder;

  localparam int unsigned MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic        fault;
  logic        th_valid;
  logic [31:0] th_data;
  logic [31:0] ld_cnt;
  logic [31:0] st_cnt;

  typedef struct {
    logic [31:0] rd;
    logic        f;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_loads = 0;
  int   m_stores = 0;

  dmem_responder #(.MEM_BYTES(MEM_BYTES)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_dmem_addr   (addr),
    .i_dmem_ren    (ren),
    .i_dmem_wen    (wen),
    .i_dmem_wdata  (wdata),
    .i_dmem_mask   (mask),
    .o_dmem_rdata  (rdata),
    .o_fault       (fault),
    .o_tohost_valid(th_valid),
    .o_tohost_data (th_data),
    .o_load_count  (ld_cnt),
    .o_store_count (st_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int c);
`ifdef DMEM_STATS_EN
    return 32'(c);
`else
    return 32'd0;
`endif
  endfunction

  // One request cycle: drive, compare combinational outputs at negedge,
  // advance past the posedge and update the counter model.
  task automatic issue(input string tag, input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] wd, input logic [3:0] m,
                       input logic [31:0] exp_rd, input logic exp_f);
    exp_t e;
    addr = a; ren = r; wen = w; wdata = wd; mask = m;
    exp_q.push_back('{rd: exp_rd, f: exp_f, tag: tag});
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.tag, "_rdata"}, rdata, e.rd);
    check({e.tag, "_fault"}, {31'd0, fault}, {31'd0, e.f});
    @(posedge clk);
    #1;
    if (rst_n && !exp_f) begin
      if (r) m_loads++;
      if (w) m_stores++;
    end
    ren = 1'b0; wen = 1'b0; mask = '0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_loads"},  ld_cnt, cnt_exp(m_loads));
    check({tag, "_stores"}, st_cnt, cnt_exp(m_stores));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("por_valid", {31'd0, th_valid}, 32'd0);
    check("por_data", th_data, 32'd0);
    check_counts("por");

    // Activity before the mid-run reset.
    issue("st30", 32'h30, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    issue("th7", 32'h8000_0000, 1'b0, 1'b1, 32'h7, 4'hF, 32'h0, 1'b0);
    issue("ld30", 32'h30, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    check("pre_valid", {31'd0, th_valid}, 32'd1);
    check_counts("pre");

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    m_loads = 0; m_stores = 0;
    check("rst_valid", {31'd0, th_valid}, 32'd0);
    check("rst_data", th_data, 32'd0);
    check_counts("rst");
    issue("rst_st", 32'h30, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    issue("rst_ld", 32'h30, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    rst_n = 1'b1;
    check_counts("rel");
    issue("cyc0", 32'h8000_0004, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    issue("cyc1", 32'h8000_0004, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0);
    issue("cyc_wr", 32'h8000_0004, 1'b0, 1'b1, 32'hFFFF, 4'hF, 32'h0, 1'b0);
    issue("cyc3", 32'h8000_0004, 1'b1, 1'b0, 32'h0, 4'h0, 32'h3, 1'b0);
    issue("ld30b", 32'h30, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

    // Full and partial word stores.
    issue("st10", 32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    issue("ld10", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    issue("stb10", 32'h10, 1'b0, 1'b1, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
    issue("ldb10", 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0);

    // Wrap-around at the top of RAM.
    issue("st0", 32'h0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0);
    issue("stwr", MEM_BYTES - 2, 1'b0, 1'b1, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    issue("ldwr", MEM_BYTES - 2, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1122_3344, 1'b0);
    issue("ld0", 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0000_1122, 1'b0);

    // Same-cycle read and write.
    issue("st20", 32'h20, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0);
    issue("rw20", 32'h20, 1'b1, 1'b1, 32'h5, 4'hF, 32'h0, 1'b0);
    issue("ld20", 32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 32'h5, 1'b0);

    // TOHOST, misses and unaligned MMIO.
    issue("th1", 32'h8000_0000, 1'b0, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0);
    check("th1_valid", {31'd0, th_valid}, 32'd1);
    check("th1_data", th_data, 32'h1);
    check_counts("pre_miss");
    issue("miss_ld", 32'h4000_0000, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    check_counts("post_miss");
    issue("unal_st", 32'h8000_0002, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    check("unal_data", th_data, 32'h1);
    issue("idle_miss", 32'h4000_0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    issue("th_lane", 32'h8000_0000, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0100, 32'h0, 1'b0);
    check("th_lane_data", th_data, 32'h00BB_0001);
    issue("th_nomask", 32'h8000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    check("th_nomask_data", th_data, 32'h00BB_0001);
    issue("th_rd", 32'h8000_0000, 1'b1, 1'b0, 32'h0, 4'h0, 32'h00BB_0001, 1'b0);

    // Counter reads: value before this read's own increment.
    issue("rd_loads", 32'h8000_0008, 1'b1, 1'b0, 32'h0, 4'h0, cnt_exp(m_loads), 1'b0);
    issue("rd_stores", 32'h8000_000C, 1'b1, 1'b0, 32'h0, 4'h0, cnt_exp(m_stores), 1'b0);
    check_counts("final");

    if (exp_q.size() != 0) check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Synthesizable data-memory responder for the hart's data-memory port: it serves the loads and stores that the hart issues.
- Byte-addressed little-endian RAM with asynchronous read (the single-cycle hart needs same-cycle load data) and synchronous masked write.
- A small MMIO window holding a tohost/halt register, a free-running cycle counter and optional access counters.
- Used in FPGA builds and self-checking simulations in place of a behavioural memory model.

Parameters:
- MEM_BYTES, 1024: RAM size in bytes; power of two.
- MEM_BASE, 32'h0000_0000: base address of the RAM region.
- MMIO_BASE, 32'h8000_0000: base address of the 16-byte MMIO window.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_dmem_addr  in  32  byte address from hart
- i_dmem_ren  in  1  load request this cycle
- i_dmem_wen  in  1  store request this cycle
- i_dmem_wdata  in  32  store data, lanes aligned to the address
- i_dmem_mask  in  4  byte-lane enables, bit n selects wdata[8n+7:8n]
- o_dmem_rdata  out  32  load data, combinational
- o_fault  out  1  combinational: the request hits neither region
- o_tohost_valid  out  1  sticky: tohost has been written
- o_tohost_data  out  32  last value written to tohost
- o_load_count  out  32  number of loads accepted (stats)
- o_store_count  out  32  number of stores accepted (stats)

Behaviour:
- Reset:
  - Asserting i_rst_n=0 asynchronously clears tohost_valid, tohost_data, the cycle counter and both access counters.
  - RAM contents are not reset.
  - While reset is asserted, stores are ignored and o_dmem_rdata still follows the combinational rule.
- Region decode:
  - RAM hit: (addr - MEM_BASE) < MEM_BYTES.
  - MMIO hit: addr[31:4] == MMIO_BASE[31:4].
  - Anything else is a miss.
  - o_fault = (ren|wen) & miss.
- RAM read:
  - Zero cycles of latency.
  - With offset o = addr - MEM_BASE, o_dmem_rdata = {m[o+3], m[o+2], m[o+1], m[o]}, with byte indices taken modulo MEM_BYTES (wrap-around at the top).
  - The mask is ignored on reads; the full word is returned.
  - Unaligned addresses are legal.
- RAM write:
  - On the posedge when wen=1 and not in reset, m[o+n] <= wdata[8n+7:8n] for each n with mask[n]=1.
  - Byte indices are taken modulo MEM_BYTES.
- Rdata gating: o_dmem_rdata = 0 when ren=0 or on a miss.
- Simultaneous ren and wen to the same address: the read returns the pre-write data; the write commits at the edge.
- MMIO map (offset addr[3:0], word-aligned; unaligned MMIO access counts as a miss and sets o_fault):
  - 0x0 TOHOST: a write with any mask bit set latches the masked lanes into tohost_data and sets tohost_valid=1 at the edge. tohost_valid stays 1 until reset. Reads return tohost_data.
  - 0x4 CYCLE: read-only. The counter increments by 1 every clock out of reset and wraps at 2^32. Writes are ignored.
  - 0x8 LOADS: read-only; returns load_count.
  - 0xC STORES: read-only; returns store_count.
- Counters:
  - load_count increments on every cycle with ren=1 and no fault.
  - store_count increments on every cycle with wen=1 and no fault.
  - A cycle with both ren and wen increments both.
  - Both counters wrap at 2^32.
- Outputs o_tohost_* are registered. o_load_count and o_store_count present the register values.

Optional Feature:
- DMEM_STATS_EN
  - Defined: load/store counters are implemented as above; MMIO 0x8/0xC return them.
  - Undefined: no counter flops exist; o_load_count = o_store_count = 0; MMIO reads of 0x8/0xC return 0; decode and fault behaviour are unchanged.

Test Plan:
- Reset with rst_n=0 mid-run, then release -> o_tohost_valid=0, o_tohost_data=0, CYCLE read = 0 on the first cycle after release, counters 0.
- Store wdata=32'hDEADBEEF, mask 4'b1111 @0x10, then load @0x10 -> rdata 32'hDEADBEEF; store 32'h000000AA mask 4'b0001 @0x10, then load -> 32'hDEADBEAA.
- Store 32'h11223344 mask 4'b1111 @MEM_BYTES-2, then load @MEM_BYTES-2 -> 32'h11223344; load @0 -> low half-word 16'h1122 (wrap-around).
- Same-cycle ren+wen @0x20 (old value 32'h0, wdata 32'h5) -> rdata 32'h0 that cycle; load next cycle -> 32'h5.
- Store 32'h1 @0x8000_0000 -> o_tohost_valid=1, o_tohost_data=32'h1 after the edge; load @0x4000_0000 -> o_fault=1, rdata 0, counters unchanged; store @0x8000_0002 -> o_fault=1.
- With DMEM_STATS_EN, issue 3 loads and 2 stores -> read @0x8000_0008 returns 3 (the read itself is counted only after the edge), @0x8000_000C returns 2; without DMEM_STATS_EN both reads return 0.
